// File: rtl/adc_thermometer_decoder.sv
// adc_thermometer_decoder: derotates, bubble-corrects and popcounts a thermometer word into a binary sample
module adc_thermometer_decoder #(
  parameter int OUTPUT_WIDTH      = 10,
  parameter int THERMOMETER_WIDTH = 8
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      valid_i,
  input  logic                                      derotate_en_i,
  input  logic [1:0]                                rotation_i,
  input  logic [2**THERMOMETER_WIDTH-1:0]           input_thermometer_i,
  input  logic [OUTPUT_WIDTH-THERMOMETER_WIDTH-1:0] input_binary_i,
  input  logic                                      err_clear_i,
  output logic                                      valid_o,
  output logic [OUTPUT_WIDTH-1:0]                   output_binary_o,
  output logic                                      bubble_o,
  output logic                                      overrange_o,
  output logic [7:0]                                err_count_o
);
  localparam int TW = THERMOMETER_WIDTH;
  localparam int L  = 2**TW;
  localparam int Q  = L/4;
  localparam int BW = OUTPUT_WIDTH-TW;
  logic [L-1:0]  t1, rot, up, dn, fix, t2;
  logic [BW-1:0] b1, b2;
  logic [1:0]    r1;
  logic          v1, v2, bub2;
  logic [TW:0]   n;
  // S1: capture the raw sample; rotation is zeroed when derotation is disabled
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      t1 <= '0;
      b1 <= '0;
      r1 <= '0;
      v1 <= 1'b0;
    end else begin
      t1 <= input_thermometer_i;
      b1 <= input_binary_i;
      r1 <= derotate_en_i ? rotation_i : 2'd0;
      v1 <= valid_i;
    end
  // rotate right by r quarter-segments, then 3-input majority with 1 below bit 0 and 0 above the top
  always_comb begin
    rot = r1 == 2'd0 ? t1 :
          r1 == 2'd1 ? {t1[Q-1:0], t1[L-1:Q]} :
          r1 == 2'd2 ? {t1[2*Q-1:0], t1[L-1:2*Q]} :
                       {t1[3*Q-1:0], t1[L-1:3*Q]};
    up  = {rot[L-2:0], 1'b1};
    dn  = {1'b0, rot[L-1:1]};
    fix = (up & rot) | (up & dn) | (rot & dn);
  end
  // S2: register the corrected word and whether correction touched it
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      t2   <= '0;
      b2   <= '0;
      bub2 <= 1'b0;
      v2   <= 1'b0;
    end else begin
      t2   <= fix;
      b2   <= b1;
      bub2 <= fix != rot;
      v2   <= v1;
    end
  // count ones of the corrected word; top bit set means every line was on
  always_comb begin
    n = '0;
    for (int i = 0; i < L; i++) n = n + (TW+1)'(t2[i]);
  end
  // S3: saturate a full-scale count and publish; data holds between valid samples
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      valid_o         <= 1'b0;
      bubble_o        <= 1'b0;
      overrange_o     <= 1'b0;
      output_binary_o <= '0;
    end else begin
      valid_o     <= v2;
      bubble_o    <= v2 & bub2;
      overrange_o <= v2 & n[TW];
      if (v2) output_binary_o <= {n[TW] ? {TW{1'b1}} : n[TW-1:0], b2};
    end
  // saturating error counter; clear wins over a simultaneous event
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) err_count_o <= '0;
    else if (err_clear_i) err_count_o <= '0;
    else if (valid_o & (bubble_o | overrange_o) & ~&err_count_o) err_count_o <= err_count_o + 8'd1;
endmodule
